xreg_seq: RTL and testbench
===========================

// Module: xreg_seq
// PURPOSE
//  Control sequencer directly upstream of the X register bit slices.
//  Turns one decoded X-register command into a timed strobe sequence:
//  - one-hot next-value select: xiz, xip, xis or xid;
//  - the wrx capture edge;
//  - the rdx abus read enable.
//  Multi-bit shifts run as repeated single-bit shift/capture rounds.
//  The sequencer guarantees mux settle time before each wrx edge and hold time after it.
// PARAMETERS
//  CNT_W   4  width of shift count input (max shift 2**CNT_W-1)
//  SETTLE  2  cycles the select is asserted before wrx rises (>=1)
//  PULSE   1  cycles wrx stays high per capture (>=1)
//  RD_CYC  2  cycles rdx is held for a read command (>=1)
// PORTS
//  clk     in   1      system clock, all state changes on rising edge
//  nrst    in   1      synchronous active-low reset
//  start   in   1      command strobe, accepted only when ready=1
//  op      in   3      000 nop, 001 ldz, 010 ldp, 011 ldd, 100 shl, 101 rd; others illegal
//  count   in   CNT_W  shift count, sampled with start, used by shl only
//  ready   out  1      sequencer idle, start will be accepted
//  done    out  1      one-cycle pulse, command complete
//  err     out  1      one-cycle pulse with done, illegal op was issued
//  xiz     out  1      select zero as next X
//  xip     out  1      select P as next X
//  xis     out  1      select neighbour bit (shift) as next X
//  xid     out  1      select dbus as next X
//  wrx     out  1      X register capture clock (rising edge captures)
//  rdx     out  1      drive X onto abus
// BEHAVIOUR
//  - One clock (clk). Reset is synchronous and active-low (nrst).
//  - Reset: state=IDLE, ready=1, all other outputs 0, count register 0.
//    Reset mid-sequence aborts at the next edge. wrx may fall; no new rising edge is produced.
//  - All outputs are registered, with no combinational path from inputs.
//  - States: IDLE, SETUP, STROBE, HOLD, READ, DONE.
//  - IDLE: ready=1. start=1 latches op/count; ready=0 from the next cycle.
//    start while ready=0 is ignored.
//  - Routing from IDLE on start:
//    - ldz/ldp/ldd, or shl with count>0 -> SETUP.
//    - rd -> READ.
//    - nop, shl with count=0, or illegal op -> DONE (illegal also sets err).
//  - SETUP: the op's select is high; wrx=0. Lasts SETTLE cycles, then -> STROBE.
//  - STROBE: select held, wrx=1. Lasts PULSE cycles, then -> HOLD.
//  - HOLD: 1 cycle, select held, wrx=0. Exit depends on the remaining count:
//    - shl with remaining>1: decrement, -> SETUP (xis stays high between rounds).
//    - otherwise -> DONE.
//  - READ: rdx=1 for RD_CYC cycles, no select, wrx=0, then -> DONE.
//  - DONE: 1 cycle, done=1 (err=1 if illegal), all selects/wrx/rdx 0, then -> IDLE.
//  - Invariants (assert in bench):
//    - at most one select is high;
//    - wrx=1 only while exactly one select is high;
//    - a select never changes while wrx=1 or in the cycle wrx falls;
//    - rdx and wrx are never both high.
//  - Latency, start sampled at edge k, defaults:
//    - load: wrx high in cycle k+3, HOLD k+4, done k+5.
//    - shl of n: SETTLE+PULSE+1 = 4 cycles per bit, done at cycle k+4n+1.
//    - rd: rdx in k+1..k+2, done k+3.
//    - nop, illegal, shl 0: done at k+1.
//  - Back-to-back: ready returns the cycle after done, so the next start is accepted at the edge ending that cycle.
// TESTING
//  1 nrst=0 for 2 cycles mid-shl -> next cycle ready=1, all strobes 0, no extra wrx rising edge.
//  2 start op=011 -> xid high cycles k+1..k+4, wrx high only k+3, done k+5, no other select.
//  3 start op=100 count=3 -> three wrx pulses 4 cycles apart, xis continuous k+1..k+12, done k+13.
//  4 start op=100 count=0, then op=111 -> each done after 1 cycle, no wrx; err=1 only for 111.
//  5 start op=101 -> rdx high 2 cycles, wrx/selects 0; start pulsed while busy is ignored.
//  6 random op/count stream with idle gaps -> invariants hold; wrx edge count equals the expected captures.

Source files
------------

// File: rtl/xreg_seq.sv
// ----------------------------------------------------------------------------
// xreg_seq
//
// Control sequencer that sits directly upstream of the X register bit slices.
// It turns one decoded X-register command into a timed strobe sequence:
//   - a one-hot next-value select (xiz / xip / xis / xid),
//   - the wrx capture edge,
//   - the rdx abus read enable.
// A multi-bit shift runs as repeated single-bit select/capture rounds.
// Each wrx pulse is preceded by Settle cycles of stable select (mux settle)
// and followed by one HOLD cycle with the select still high (hold time).
//
// Ports
//   clk_i      system clock, all state changes on the rising edge
//   nrst_i     synchronous active-low reset
//   start_i    command strobe, accepted only while ready_o=1
//   op_i       000 nop, 001 ldz, 010 ldp, 011 ldd, 100 shl, 101 rd, others illegal
//   count_i    shift count, sampled with start_i, used by shl only
//   ready_o    sequencer idle, start_i will be accepted
//   done_o     one-cycle pulse, command complete
//   err_o      one-cycle pulse together with done_o for an illegal op
//   xiz_o      select zero as next X
//   xip_o      select P as next X
//   xis_o      select neighbour bit (shift) as next X
//   xid_o      select dbus as next X
//   wrx_o      X register capture clock (rising edge captures)
//   rdx_o      drive X onto abus
//
// Every output is a flop loaded from the next-state decode, so no input has a
// combinational path to any output.
// ----------------------------------------------------------------------------
module xreg_seq #(
    parameter int unsigned CntW   = 4,  // shift count width
    parameter int unsigned Settle = 2,  // select-before-wrx cycles (>=1)
    parameter int unsigned Pulse  = 1,  // wrx high cycles per capture (>=1)
    parameter int unsigned RdCyc  = 2   // rdx high cycles for a read (>=1)
) (
    input  logic            clk_i,
    input  logic            nrst_i,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [CntW-1:0] count_i,
    output logic            ready_o,
    output logic            done_o,
    output logic            err_o,
    output logic            xiz_o,
    output logic            xip_o,
    output logic            xis_o,
    output logic            xid_o,
    output logic            wrx_o,
    output logic            rdx_o
);

    // Command encodings
    localparam logic [2:0] OpNop = 3'b000;
    localparam logic [2:0] OpLdz = 3'b001;
    localparam logic [2:0] OpLdp = 3'b010;
    localparam logic [2:0] OpLdd = 3'b011;
    localparam logic [2:0] OpShl = 3'b100;
    localparam logic [2:0] OpRd  = 3'b101;

    // Phase timer: wide enough for the longest timed state.
    localparam int unsigned TmrMax0 = (Settle > Pulse) ? Settle : Pulse;
    localparam int unsigned TmrMax  = (TmrMax0 > RdCyc) ? TmrMax0 : RdCyc;
    localparam int unsigned TmrW    = (TmrMax > 1) ? $clog2(TmrMax) : 1;

    // Timers count down to zero; loaded with length-1 on state entry.
    localparam logic [TmrW-1:0] SettleLd = TmrW'(Settle - 1);
    localparam logic [TmrW-1:0] PulseLd  = TmrW'(Pulse - 1);
    localparam logic [TmrW-1:0] RdLd     = TmrW'(RdCyc - 1);
    localparam logic [TmrW-1:0] TmrZero  = '0;
    localparam logic [TmrW-1:0] TmrOne   = TmrW'(1);
    localparam logic [CntW-1:0] CntZero  = '0;
    localparam logic [CntW-1:0] CntOne   = CntW'(1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStrobe,
        StHold,
        StRead,
        StDone
    } state_e;

    // Sequencer state
    state_e          state_q, state_d;
    logic [TmrW-1:0] tmr_q,   tmr_d;
    logic [CntW-1:0] rem_q,   rem_d;   // shift rounds still to run, incl. current
    logic [2:0]      op_q,    op_d;
    logic            ill_q,   ill_d;   // latched illegal-op flag for err_o

    // Registered outputs
    logic ready_q, ready_d;
    logic done_q,  done_d;
    logic err_q,   err_d;
    logic xiz_q,   xiz_d;
    logic xip_q,   xip_d;
    logic xis_q,   xis_d;
    logic xid_q,   xid_d;
    logic wrx_q,   wrx_d;
    logic rdx_q,   rdx_d;

    logic sel_phase;   // next state is one with the select asserted

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        rem_d   = rem_q;
        op_d    = op_q;
        ill_d   = ill_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    op_d  = op_i;
                    rem_d = count_i;
                    ill_d = 1'b0;
                    unique case (op_i)
                        OpLdz, OpLdp, OpLdd: begin
                            state_d = StSetup;
                            tmr_d   = SettleLd;
                        end
                        OpShl: begin
                            if (count_i != CntZero) begin
                                state_d = StSetup;
                                tmr_d   = SettleLd;
                            end else begin
                                state_d = StDone;
                            end
                        end
                        OpRd: begin
                            state_d = StRead;
                            tmr_d   = RdLd;
                        end
                        OpNop: begin
                            state_d = StDone;
                        end
                        default: begin
                            state_d = StDone;
                            ill_d   = 1'b1;
                        end
                    endcase
                end
            end

            StSetup: begin
                if (tmr_q == TmrZero) begin
                    state_d = StStrobe;
                    tmr_d   = PulseLd;
                end else begin
                    tmr_d = tmr_q - TmrOne;
                end
            end

            StStrobe: begin
                if (tmr_q == TmrZero) begin
                    state_d = StHold;
                end else begin
                    tmr_d = tmr_q - TmrOne;
                end
            end

            StHold: begin
                // Another shift round keeps xis high straight through to SETUP.
                if ((op_q == OpShl) && (rem_q > CntOne)) begin
                    rem_d   = rem_q - CntOne;
                    state_d = StSetup;
                    tmr_d   = SettleLd;
                end else begin
                    state_d = StDone;
                end
            end

            StRead: begin
                if (tmr_q == TmrZero) begin
                    state_d = StDone;
                end else begin
                    tmr_d = tmr_q - TmrOne;
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output decode from the next state, registered below
    // ------------------------------------------------------------------------
    always_comb begin
        sel_phase = (state_d == StSetup) || (state_d == StStrobe) || (state_d == StHold);

        ready_d = (state_d == StIdle);
        done_d  = (state_d == StDone);
        err_d   = (state_d == StDone) && ill_d;
        xiz_d   = sel_phase && (op_d == OpLdz);
        xip_d   = sel_phase && (op_d == OpLdp);
        xis_d   = sel_phase && (op_d == OpShl);
        xid_d   = sel_phase && (op_d == OpLdd);
        wrx_d   = (state_d == StStrobe);
        rdx_d   = (state_d == StRead);
    end

    // ------------------------------------------------------------------------
    // State and output registers, synchronous active-low reset
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            state_q <= StIdle;
            tmr_q   <= '0;
            rem_q   <= '0;
            op_q    <= OpNop;
            ill_q   <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            xiz_q   <= 1'b0;
            xip_q   <= 1'b0;
            xis_q   <= 1'b0;
            xid_q   <= 1'b0;
            wrx_q   <= 1'b0;
            rdx_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
            ill_q   <= ill_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            err_q   <= err_d;
            xiz_q   <= xiz_d;
            xip_q   <= xip_d;
            xis_q   <= xis_d;
            xid_q   <= xid_d;
            wrx_q   <= wrx_d;
            rdx_q   <= rdx_d;
        end
    end

    assign ready_o = ready_q;
    assign done_o  = done_q;
    assign err_o   = err_q;
    assign xiz_o   = xiz_q;
    assign xip_o   = xip_q;
    assign xis_o   = xis_q;
    assign xid_o   = xid_q;
    assign wrx_o   = wrx_q;
    assign rdx_o   = rdx_q;

endmodule

// File: tb/tb_xreg_seq.sv
// ----------------------------------------------------------------------------
// tb_xreg_seq
//
// Directed bench for xreg_seq with default parameters. Each task drives one
// scenario and compares the packed output vector cycle by cycle against
// hand-derived expectations. A negedge monitor checks the strobe invariants
// and counts wrx rising edges.
// Output vector order: {ready, done, err, xiz, xip, xis, xid, wrx, rdx}.
// ----------------------------------------------------------------------------
module tb_xreg_seq;

    localparam logic [8:0] BRdy  = 9'h100;
    localparam logic [8:0] BDone = 9'h080;
    localparam logic [8:0] BErr  = 9'h040;
    localparam logic [8:0] BXiz  = 9'h020;
    localparam logic [8:0] BXip  = 9'h010;
    localparam logic [8:0] BXis  = 9'h008;
    localparam logic [8:0] BXid  = 9'h004;
    localparam logic [8:0] BWrx  = 9'h002;
    localparam logic [8:0] BRdx  = 9'h001;

    logic       clk_i = 1'b0;
    logic       nrst_i = 1'b0;
    logic       start_i = 1'b0;
    logic [2:0] op_i = 3'b000;
    logic [3:0] count_i = 4'd0;
    logic ready_o, done_o, err_o, xiz_o, xip_o, xis_o, xid_o, wrx_o, rdx_o;

    int n_cmp = 0;
    int n_bad = 0;
    int wrx_edges = 0;
    bit mon_en = 1'b0;

    xreg_seq dut (
        .clk_i   (clk_i),
        .nrst_i  (nrst_i),
        .start_i (start_i),
        .op_i    (op_i),
        .count_i (count_i),
        .ready_o (ready_o),
        .done_o  (done_o),
        .err_o   (err_o),
        .xiz_o   (xiz_o),
        .xip_o   (xip_o),
        .xis_o   (xis_o),
        .xid_o   (xid_o),
        .wrx_o   (wrx_o),
        .rdx_o   (rdx_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [8:0] obs();
        return {ready_o, done_o, err_o, xiz_o, xip_o, xis_o, xid_o, wrx_o, rdx_o};
    endfunction

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Wait (bounded) for ready, then present one command across one edge.
    // Returns in the first cycle after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [3:0] cnt);
        int w;
        w = 0;
        while (ready_o !== 1'b1 && w < 200) begin
            step();
            w++;
        end
        if (ready_o !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_ready: ready=%b required 1", ready_o);
        end
        start_i = 1'b1;
        op_i    = op;
        count_i = cnt;
        step();
        start_i = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Invariant monitor
    // ------------------------------------------------------------------------
    logic [3:0] prev_sel  = 4'b0000;
    logic       prev_wrx  = 1'b0;
    logic       prev_nrst = 1'b0;

    always @(negedge clk_i) begin
        logic [3:0] sels;
        sels = {xiz_o, xip_o, xis_o, xid_o};
        if (mon_en) begin
            n_cmp++;
            if ($countones(sels) > 1) begin
                n_bad++;
                $display("FAIL inv_onehot: selects=%b required at most one high", sels);
            end
            if (wrx_o) begin
                n_cmp++;
                if ($countones(sels) != 1) begin
                    n_bad++;
                    $display("FAIL inv_wrx_sel: selects=%b required exactly one with wrx", sels);
                end
            end
            // Reset may drop a select while wrx falls; that edge is exempt.
            if (prev_wrx && prev_nrst) begin
                n_cmp++;
                if (sels !== prev_sel) begin
                    n_bad++;
                    $display("FAIL inv_sel_stable: selects=%b required %b", sels, prev_sel);
                end
            end
            n_cmp++;
            if (wrx_o && rdx_o) begin
                n_bad++;
                $display("FAIL inv_rd_wr: wrx=%b rdx=%b required not both", wrx_o, rdx_o);
            end
            if (wrx_o && !prev_wrx) wrx_edges++;
        end
        prev_sel  = sels;
        prev_wrx  = wrx_o;
        prev_nrst = nrst_i;
    end

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset();
        nrst_i = 1'b0;
        step();
        step();
        n_cmp++;
        if (obs() !== BRdy) begin
            n_bad++;
            $display("FAIL reset_state: outputs=%b required %b", obs(), BRdy);
        end
        nrst_i = 1'b1;
        step();
        n_cmp++;
        if (obs() !== BRdy) begin
            n_bad++;
            $display("FAIL reset_idle: outputs=%b required %b", obs(), BRdy);
        end
        mon_en = 1'b1;
    endtask

    // ldz / ldp / ldd: select k+1..k+4, wrx k+3, done k+5, ready k+6.
    task automatic test_load();
        logic [2:0] ops [3];
        logic [8:0] sel [3];
        logic [8:0] exp_v;
        int e0;
        ops = '{3'b001, 3'b010, 3'b011};
        sel = '{BXiz, BXip, BXid};
        for (int i = 0; i < 3; i++) begin
            e0 = wrx_edges;
            issue(ops[i], 4'd0);
            for (int c = 1; c <= 6; c++) begin
                exp_v = '0;
                if (c <= 4) exp_v |= sel[i];
                if (c == 3) exp_v |= BWrx;
                if (c == 5) exp_v |= BDone;
                if (c == 6) exp_v |= BRdy;
                n_cmp++;
                if (obs() !== exp_v) begin
                    n_bad++;
                    $display("FAIL load op=%b cyc=k+%0d: outputs=%b required %b",
                             ops[i], c, obs(), exp_v);
                end
                if (c < 6) step();
            end
            n_cmp++;
            if (wrx_edges - e0 != 1) begin
                n_bad++;
                $display("FAIL load_edges op=%b: edges=%0d required 1", ops[i], wrx_edges - e0);
            end
        end
    endtask

    // shl 3: xis k+1..k+12, wrx at k+3/7/11, done k+13, ready k+14.
    task automatic test_shift();
        logic [8:0] exp_v;
        int e0;
        e0 = wrx_edges;
        issue(3'b100, 4'd3);
        for (int c = 1; c <= 14; c++) begin
            exp_v = '0;
            if (c <= 12) exp_v |= BXis;
            if (c <= 12 && (c % 4) == 3) exp_v |= BWrx;
            if (c == 13) exp_v |= BDone;
            if (c == 14) exp_v |= BRdy;
            n_cmp++;
            if (obs() !== exp_v) begin
                n_bad++;
                $display("FAIL shl3 cyc=k+%0d: outputs=%b required %b", c, obs(), exp_v);
            end
            if (c < 14) step();
        end
        n_cmp++;
        if (wrx_edges - e0 != 3) begin
            n_bad++;
            $display("FAIL shl3_edges: edges=%0d required 3", wrx_edges - e0);
        end
    endtask

    // nop, shl 0 and illegal ops finish in one cycle with no capture.
    task automatic test_short();
        logic [2:0] ops [4];
        logic [8:0] d1;
        int e0;
        ops = '{3'b100, 3'b111, 3'b000, 3'b110};
        e0 = wrx_edges;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], 4'd0);
            d1 = BDone;
            if (ops[i][2:1] == 2'b11) d1 |= BErr;
            n_cmp++;
            if (obs() !== d1) begin
                n_bad++;
                $display("FAIL short op=%b cyc=k+1: outputs=%b required %b", ops[i], obs(), d1);
            end
            step();
            n_cmp++;
            if (obs() !== BRdy) begin
                n_bad++;
                $display("FAIL short op=%b cyc=k+2: outputs=%b required %b", ops[i], obs(), BRdy);
            end
        end
        n_cmp++;
        if (wrx_edges != e0) begin
            n_bad++;
            $display("FAIL short_edges: edges=%0d required 0", wrx_edges - e0);
        end
    endtask

    // rd: rdx k+1..k+2, done k+3; an ldd start pulsed while busy is dropped.
    task automatic test_read();
        logic [8:0] exp_v;
        issue(3'b101, 4'd0);
        for (int c = 1; c <= 6; c++) begin
            exp_v = '0;
            if (c <= 2) exp_v = BRdx;
            if (c == 3) exp_v = BDone;
            if (c >= 4) exp_v = BRdy;
            n_cmp++;
            if (obs() !== exp_v) begin
                n_bad++;
                $display("FAIL read cyc=k+%0d: outputs=%b required %b", c, obs(), exp_v);
            end
            start_i = (c == 1 || c == 2);
            op_i    = 3'b011;
            step();
        end
        start_i = 1'b0;
    endtask

    // Next command is accepted at the edge ending the first ready cycle.
    task automatic test_back_to_back();
        issue(3'b001, 4'd0);
        for (int c = 1; c < 6; c++) step();
        n_cmp++;
        if (obs() !== BRdy) begin
            n_bad++;
            $display("FAIL b2b_ready: outputs=%b required %b", obs(), BRdy);
        end
        issue(3'b010, 4'd0);
        n_cmp++;
        if (obs() !== BXip) begin
            n_bad++;
            $display("FAIL b2b_next: outputs=%b required %b", obs(), BXip);
        end
        for (int c = 1; c < 6; c++) step();
    endtask

    // Reset held 2 cycles while a shift is strobing.
    task automatic test_reset_mid();
        int e0;
        issue(3'b100, 4'd3);
        step();
        step();
        n_cmp++;
        if (obs() !== (BXis | BWrx)) begin
            n_bad++;
            $display("FAIL rstmid_pre: outputs=%b required %b", obs(), BXis | BWrx);
        end
        nrst_i = 1'b0;
        step();
        step();
        nrst_i = 1'b1;
        n_cmp++;
        if (obs() !== BRdy) begin
            n_bad++;
            $display("FAIL rstmid_after: outputs=%b required %b", obs(), BRdy);
        end
        e0 = wrx_edges;
        for (int c = 0; c < 6; c++) step();
        n_cmp++;
        if (obs() !== BRdy || wrx_edges != e0) begin
            n_bad++;
            $display("FAIL rstmid_quiet: outputs=%b edges=%0d required %b and 0 edges",
                     obs(), wrx_edges - e0, BRdy);
        end
    endtask

    // Random commands with idle gaps; captures and err checked per command.
    task automatic test_random();
        logic [2:0] op;
        logic [3:0] cnt;
        int exp_edges;
        int e0;
        int w;
        e0 = wrx_edges;
        exp_edges = 0;
        for (int i = 0; i < 30; i++) begin
            op  = 3'($urandom_range(0, 7));
            cnt = 4'($urandom_range(0, 5));
            if (op == 3'b001 || op == 3'b010 || op == 3'b011) exp_edges += 1;
            if (op == 3'b100) exp_edges += int'(cnt);
            issue(op, cnt);
            w = 0;
            while (done_o !== 1'b1 && w < 100) begin
                step();
                w++;
            end
            n_cmp++;
            if (done_o !== 1'b1 || err_o !== (op[2:1] == 2'b11)) begin
                n_bad++;
                $display("FAIL rand_done op=%b cnt=%0d: done=%b err=%b required 1 and %b",
                         op, cnt, done_o, err_o, (op[2:1] == 2'b11));
            end
            for (int g = 0; g <= int'($urandom_range(0, 3)); g++) step();
        end
        n_cmp++;
        if (wrx_edges - e0 != exp_edges) begin
            n_bad++;
            $display("FAIL rand_edges: edges=%0d required %0d", wrx_edges - e0, exp_edges);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_shift();
        test_short();
        test_read();
        test_back_to_back();
        test_reset_mid();
        test_random();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
